// File: rtl/lcd_fpdlink_tx_if.sv
// Pixel-fetch link between the FPD-Link transmitter (master) and the upstream frame source (slave).
interface lcd_fpdlink_tx_if;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [23:0] pix_data;

    modport master (output pix_req, output pix_x, output pix_y, input pix_data);
    modport slave  (input pix_req, input pix_x, input pix_y, output pix_data);
endinterface

// File: rtl/lcd_fpdlink_tx.sv
// FPD-Link/OpenLDI transmit core: panel timing, pixel fetch and 7:1 lane word packing.
// Defining LCD_TESTPAT_EN adds the pat_sel input and an internal 8-bar colour generator.
module lcd_fpdlink_tx #(
    parameter int LANES     = 4,
    parameter int MAP_JEIDA = 0,
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 160,
    parameter int H_SYNC    = 20,
    parameter int H_BP      = 140,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 12,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 20,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
`ifdef LCD_TESTPAT_EN
    input  logic                 pat_sel,
`endif
    lcd_fpdlink_tx_if.master     pix,
    output logic [7*LANES-1:0]   lane_data,
    output logic [6:0]           clk_word,
    output logic                 frame_start,
    output logic [11:0]          line_cnt
);

    localparam int          H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int          LW          = 7 * LANES;
    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT       = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT       = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG      = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END      = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG      = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END      = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        WIDE_MAP    = (LANES == 4) && (MAP_JEIDA == 0);
    localparam logic        HS_INV      = (HS_POL != 0);
    localparam logic        VS_INV      = (VS_POL != 0);
    localparam logic [6:0]  CLK_PATTERN = 7'b1100011;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] y;
    } ctl_t;

    logic [11:0] h, v, h_nxt, v_nxt, x_nxt;
    ctl_t        s0, s0_nxt, s1;
    logic        req_nxt;
    logic        pat_now;
    logic [23:0] pixel;
    logic [27:0] lane_words, blank_words;

    assign clk_word = CLK_PATTERN;

    // Stage 0 next state: timing counters plus the control flags of the pixel being requested.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        h_nxt   = '0;
        v_nxt   = '0;
        x_nxt   = '0;
        s0_nxt  = '0;
        req_nxt = 1'b0;
        if (en) begin
            h_nxt = (h == H_LAST) ? '0 : h + 12'd1;
            v_nxt = v;
            if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + 12'd1;
            x_nxt     = h;
            s0_nxt.de = (h < H_ACT) && (v < V_ACT);
            s0_nxt.hs = (h >= HS_BEG) && (h < HS_END);
            s0_nxt.vs = (v >= VS_BEG) && (v < VS_END);
            s0_nxt.fs = (h == '0) && (v == '0);
            s0_nxt.y  = v;
            req_nxt   = s0_nxt.de && !pat_now;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            s0          <= '0;
            pix.pix_req <= 1'b0;
            pix.pix_x   <= '0;
            pix.pix_y   <= '0;
        end else begin
            h           <= h_nxt;
            v           <= v_nxt;
            s0          <= s0_nxt;
            pix.pix_req <= req_nxt;
            pix.pix_x   <= x_nxt;
            pix.pix_y   <= s0_nxt.y;
        end
    end

`ifdef LCD_TESTPAT_EN
    localparam int          BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic        pat_on, pat0, pat1;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx, bar0, bar1;

    // The selection is latched at the top-left pixel so a frame is never mixed.
    assign pat_now = ((h == '0) && (v == '0)) ? pat_sel : pat_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_on  <= 1'b0;
            pat0    <= 1'b0;
            pat1    <= 1'b0;
            bar_cnt <= '0;
            bar_idx <= '0;
            bar0    <= '0;
            bar1    <= '0;
        end else begin
            pat0 <= en && pat_now;
            bar0 <= bar_idx;
            pat1 <= pat0;
            bar1 <= bar0;
            if (en && (h == '0) && (v == '0)) pat_on <= pat_sel;
            if (!en || (h == H_LAST)) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (h < H_ACT) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end
        end
    end
`else
    assign pat_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1 <= '0;
        else     s1 <= s0;
    end

    // Stage 1 pixel; bar index bits encode the colour order white..black directly.
    always_comb begin
        pixel = pix.pix_data;
`ifdef LCD_TESTPAT_EN
        if (pat1) pixel = {{8{~bar1[1]}}, {8{~bar1[2]}}, {8{~bar1[0]}}};
`endif
        if (!s1.de) pixel = '0;
    end

    // High field fills the 6 main lane slots; the 2-bit extra field goes to lane 3.
    function automatic logic [27:0] pack_lanes(input logic [23:0] rgb, input logic de,
                                               input logic hs, input logic vs);
        logic [5:0] rh, gh, bh;
        logic [1:0] rx, gx, bx;
        if (WIDE_MAP) begin
            {rx, rh} = rgb[23:16];
            {gx, gh} = rgb[15:8];
            {bx, bh} = rgb[7:0];
        end else begin
            {rh, rx} = rgb[23:16];
            {gh, gx} = rgb[15:8];
            {bh, bx} = rgb[7:0];
        end
        return {1'b0, bx, gx, rx, de, vs, hs, bh[5:2], bh[1:0], gh[5:1], gh[0], rh};
    endfunction

    assign lane_words  = pack_lanes(pixel, s1.de, s1.hs ^ HS_INV, s1.vs ^ VS_INV);
    assign blank_words = pack_lanes('0, 1'b0, HS_INV, VS_INV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_data   <= blank_words[LW-1:0];
            frame_start <= 1'b0;
            line_cnt    <= '0;
        end else begin
            lane_data   <= lane_words[LW-1:0];
            frame_start <= s1.fs;
            line_cnt    <= s1.y;
        end
    end

endmodule

// File: tb/tb_lcd_fpdlink_tx.sv
// Self-checking bench for lcd_fpdlink_tx: three parameter variants against a frame-position model.
// Defining LCD_TESTPAT_EN also exercises the colour-bar generator.
module tb_lcd_fpdlink_tx;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [6:0] CLK_PAT = 7'b1100011;

    typedef struct packed {
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic [11:0] line;
        logic [6:0]  ck;
    } ctl_t;

    typedef struct packed {
        ctl_t        a;
        ctl_t        b;
        ctl_t        c;
        logic [27:0] la;
        logic [27:0] lb;
        logic [20:0] lc;
    } obs_t;

    typedef struct {
        bit de, hs, vs, fs, pat;
        int x, y;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        pat_sel = 1'b0;
    logic [23:0] pix_data = '0;

    logic [27:0] lane_a, lane_b;
    logic [20:0] lane_c;
    logic [6:0]  ck_a, ck_b, ck_c;
    logic        fs_a, fs_b, fs_c;
    logic [11:0] line_a, line_b, line_c;

    int total = 0;
    int bad   = 0;

    // model state
    int     n;
    bit     pat_frame;
    stage_t m0, m1;
    obs_t   expv;

    lcd_fpdlink_tx_if ifa ();
    lcd_fpdlink_tx_if ifb ();
    lcd_fpdlink_tx_if ifc ();
    assign ifa.pix_data = pix_data;
    assign ifb.pix_data = pix_data;
    assign ifc.pix_data = pix_data;

    lcd_fpdlink_tx #(.LANES(4), .MAP_JEIDA(0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(0), .VS_POL(0)) u_a (
        .clk(clk), .rst(rst), .en(en),
`ifdef LCD_TESTPAT_EN
        .pat_sel(pat_sel),
`endif
        .pix(ifa), .lane_data(lane_a), .clk_word(ck_a), .frame_start(fs_a), .line_cnt(line_a));

    lcd_fpdlink_tx #(.LANES(4), .MAP_JEIDA(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1), .VS_POL(0)) u_b (
        .clk(clk), .rst(rst), .en(en),
`ifdef LCD_TESTPAT_EN
        .pat_sel(pat_sel),
`endif
        .pix(ifb), .lane_data(lane_b), .clk_word(ck_b), .frame_start(fs_b), .line_cnt(line_b));

    lcd_fpdlink_tx #(.LANES(3), .MAP_JEIDA(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(0), .VS_POL(1)) u_c (
        .clk(clk), .rst(rst), .en(en),
`ifdef LCD_TESTPAT_EN
        .pat_sel(pat_sel),
`endif
        .pix(ifc), .lane_data(lane_c), .clk_word(ck_c), .frame_start(fs_c), .line_cnt(line_c));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Lane words written straight from the mapping tables.
    function automatic logic [27:0] lanes_exp(input int lanes, input bit jeida, input bit hinv,
                                              input bit vinv, input bit de, input bit hs,
                                              input bit vs, input logic [23:0] rgb);
        logic [7:0] r, g, b;
        logic [6:0] l0, l1, l2, l3;
        logic       hl, vl;
        r  = rgb[23:16];
        g  = rgb[15:8];
        b  = rgb[7:0];
        hl = hs ^ hinv;
        vl = vs ^ vinv;
        if (lanes == 4 && !jeida) begin
            l0 = {g[0], r[5], r[4], r[3], r[2], r[1], r[0]};
            l1 = {b[1], b[0], g[5], g[4], g[3], g[2], g[1]};
            l2 = {de, vl, hl, b[5], b[4], b[3], b[2]};
            l3 = {1'b0, b[7], b[6], g[7], g[6], r[7], r[6]};
        end else begin
            l0 = {g[2], r[7], r[6], r[5], r[4], r[3], r[2]};
            l1 = {b[3], b[2], g[7], g[6], g[5], g[4], g[3]};
            l2 = {de, vl, hl, b[7], b[6], b[5], b[4]};
            l3 = {1'b0, b[1], b[0], g[1], g[0], r[1], r[0]};
        end
        if (lanes == 3) l3 = 7'd0;
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.a.req = ifa.pix_req; o.a.x = ifa.pix_x; o.a.y = ifa.pix_y;
        o.a.fs  = fs_a; o.a.line = line_a; o.a.ck = ck_a;
        o.b.req = ifb.pix_req; o.b.x = ifb.pix_x; o.b.y = ifb.pix_y;
        o.b.fs  = fs_b; o.b.line = line_b; o.b.ck = ck_b;
        o.c.req = ifc.pix_req; o.c.x = ifc.pix_x; o.c.y = ifc.pix_y;
        o.c.fs  = fs_c; o.c.line = line_c; o.c.ck = ck_c;
        o.la = lane_a;
        o.lb = lane_b;
        o.lc = lane_c;
        return o;
    endfunction

    task automatic set_lanes(input stage_t s, input logic [23:0] rgb);
        logic [27:0] t;
        expv.la = lanes_exp(4, 0, 0, 0, s.de, s.hs, s.vs, rgb);
        expv.lb = lanes_exp(4, 1, 1, 0, s.de, s.hs, s.vs, rgb);
        t       = lanes_exp(3, 1, 0, 1, s.de, s.hs, s.vs, rgb);
        expv.lc = t[20:0];
    endtask

    task automatic model_reset();
        n         = 0;
        pat_frame = 1'b0;
        m0        = '{default: 0};
        m1        = '{default: 0};
        expv.a    = '{req: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0, line: 12'd0, ck: CLK_PAT};
        expv.b    = expv.a;
        expv.c    = expv.a;
        set_lanes(m1, 24'h0);
    endtask

    // Frame position p = n mod FT gives (h, v); results emerge two clocks after the request.
    task automatic model_step();
        logic [23:0] px;
        int p, h, v;
        if (rst) begin
            model_reset();
            return;
        end
        px = 24'h0;
        if (m1.de) px = m1.pat ? bar_rgb(m1.x / (HA / 8)) : pix_data;
        set_lanes(m1, px);
        expv.a.fs   = m1.fs;
        expv.a.line = 12'(m1.y);
        m1 = m0;
        if (en) begin
            p = n % FT;
            h = p % HT;
            v = p / HT;
            if (p == 0) pat_frame = pat_sel;
            m0.de  = (h < HA) && (v < VA);
            m0.hs  = (h >= HA + HF) && (h < HA + HF + HS);
            m0.vs  = (v >= VA + VF) && (v < VA + VF + VS);
            m0.fs  = (p == 0);
            m0.pat = pat_frame;
            m0.x   = h;
            m0.y   = v;
            n++;
        end else begin
            n  = 0;
            m0 = '{default: 0};
        end
        expv.a.req = m0.de && !m0.pat;
        expv.a.x   = 12'(m0.x);
        expv.a.y   = 12'(m0.y);
        expv.b     = expv.a;
        expv.c     = expv.a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        obs_t o;
        int last_fs, gap;
        last_fs = -1;
        for (int i = 0; i < 2 * FT + 20; i++) begin
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL frame cyc=%0d got=%h want=%h", i, o, expv);
            end
            if (fs_a) begin
                if (last_fs >= 0) begin
                    gap = i - last_fs;
                    total++;
                    if (gap !== FT) begin
                        bad++;
                        $display("FAIL frame_gap got=%0d want=%0d", gap, FT);
                    end
                end
                last_fs = i;
            end
            pix_data = 24'($urandom);
        end
    endtask

    task automatic test_mapping();
        obs_t o;
        logic [23:0] pats [2];
        pats[0] = 24'h814224;
        pats[1] = 24'hFC03FC;
        for (int k = 0; k < 2; k++) begin
            pix_data = pats[k];
            for (int i = 0; i < FT; i++) begin
                tick();
                o = observe();
                total++;
                if (o !== expv) begin
                    bad++;
                    $display("FAIL map%0d cyc=%0d got=%h want=%h", k, i, o, expv);
                end
                if (k == 1 && lane_c[20] && i > 2) begin
                    total++;
                    if (lane_c[5:0] !== 6'h3F) begin
                        bad++;
                        $display("FAIL map3_l0 got=%h want=%h", lane_c[5:0], 6'h3F);
                    end
                end
            end
        end
    endtask

    task automatic test_enable();
        obs_t o;
        logic [27:0] blank;
        int req_at, fs_at;
        for (int i = 0; i < 2 * FT && (n % FT) != 2 * HT + 5; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL en_run cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL en_off cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
        blank = lanes_exp(4, 0, 0, 0, 0, 0, 0, 24'h0);
        total++;
        if (lane_a !== blank || ck_a !== CLK_PAT) begin
            bad++;
            $display("FAIL en_blank got=%h/%b want=%h/%b", lane_a, ck_a, blank, CLK_PAT);
        end
        en = 1'b1;
        req_at = -1;
        fs_at  = -1;
        for (int i = 0; i < 12; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL en_on cyc=%0d got=%h want=%h", i, o, expv);
            end
            if (req_at < 0 && ifa.pix_req) req_at = i;
            if (fs_at < 0 && fs_a) fs_at = i;
        end
        total++;
        if (req_at < 0 || fs_at - req_at != 2) begin
            bad++;
            $display("FAIL en_fs_delay got req=%0d fs=%0d want fs-req=2", req_at, fs_at);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        for (int i = 0; i < 2 * FT && (n % FT) != HT + 4; i++) begin
            pix_data = 24'($urandom);
            tick();
        end
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        o = observe();
        total++;
        if (o !== expv) begin
            bad++;
            $display("FAIL async_rst got=%h want=%h", o, expv);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < HT + 4; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL post_rst cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
    endtask

`ifdef LCD_TESTPAT_EN
    task automatic test_pattern();
        obs_t o;
        pat_sel = 1'b1;
        for (int i = 0; i < 2 * FT + 10; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL pattern cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
        pat_sel = 1'b0;
        for (int i = 0; i < FT + 10; i++) begin
            pix_data = 24'($urandom);
            tick();
            o = observe();
            total++;
            if (o !== expv) begin
                bad++;
                $display("FAIL pattern_off cyc=%0d got=%h want=%h", i, o, expv);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_frame();
        test_mapping();
        test_enable();
        test_async_reset();
`ifdef LCD_TESTPAT_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
